// File: rtl/parking_gate_ctrl.sv
// Entry-gate controller: password sequencing, tailgate detection, retry lockout
// and lot occupancy tracking for the car parking system.
module parking_gate_ctrl #(
    parameter int                  CAPACITY       = 8,
    parameter int                  PW_WIDTH       = 4,
    parameter logic [PW_WIDTH-1:0] PASSWORD       = 4'hA,
    parameter int                  TIMEOUT_CYCLES = 8,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCK_CYCLES    = 16,
    parameter int                  BLINK_DIV      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sensor_entrance,
    input  logic                            sensor_exit,
    input  logic                            lane_exit,
    input  logic                            pw_valid,
    input  logic [PW_WIDTH-1:0]             pw_data,
    output logic                            gate_open,
    output logic                            green_led,
    output logic                            red_led,
    output logic                            alarm,
    output logic                            full,
    output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
    output logic [2:0]                      state_code
);

    localparam int OCC_W = $clog2(CAPACITY + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_PW = 3'd1,
        WRONG   = 3'd2,
        GRANTED = 3'd3,
        STOP    = 3'd4,
        LOCKED  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic [OCC_W-1:0]   occ_q;
    logic [BLK_W-1:0]   blk_cnt;
    logic               blink_phase;
    logic               occ_inc;
    logic               pw_match;

    assign pw_match   = pw_valid && (pw_data == PASSWORD);
    assign full       = (occ_q == OCC_W'(CAPACITY));
    assign occupancy  = occ_q;
    assign state_code = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tries_q <= '0;
            tmo_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            tmo_q   <= tmo_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        tmo_d     = tmo_q;
        lock_d    = lock_q;
        occ_inc   = 1'b0;
        gate_open = 1'b0;
        green_led = 1'b0;
        red_led   = 1'b0;
        alarm     = 1'b0;
        case (state_q)
            IDLE: begin
                red_led = full;
                tries_d = '0;
                tmo_d   = '0;
                if (sensor_entrance && !full) state_d = WAIT_PW;
            end
            WAIT_PW, WRONG: begin
                red_led = (state_q == WAIT_PW) ? 1'b1 : blink_phase;
                // A strobe on the terminal idle cycle wins over the timeout.
                if (pw_valid) begin
                    tmo_d = '0;
                    if (pw_match) begin
                        state_d = GRANTED;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                        if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                            state_d = LOCKED;
                            lock_d  = '0;
                        end else begin
                            state_d = WRONG;
                        end
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            GRANTED: begin
                green_led = blink_phase;
                gate_open = 1'b1;
                if (sensor_entrance && sensor_exit) begin
                    state_d = STOP;
                end else if (sensor_exit) begin
                    state_d = IDLE;
                    occ_inc = 1'b1;
                end
            end
            STOP: begin
                red_led = blink_phase;
                alarm   = 1'b1;
                if (pw_match) state_d = GRANTED;
            end
            LOCKED: begin
                red_led = 1'b1;
                alarm   = 1'b1;
                if (lock_q == LCK_W'(LOCK_CYCLES - 1)) begin
                    state_d = IDLE;
                    tries_d = '0;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + LCK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous admit and lane exit cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (occ_inc && !lane_exit) begin
            if (occ_q != OCC_W'(CAPACITY)) occ_q <= occ_q + OCC_W'(1);
        end else if (lane_exit && !occ_inc) begin
            if (occ_q != '0) occ_q <= occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blk_cnt <= blk_cnt + BLK_W'(1);
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: a behavioural lot model predicts each
// cycle's outputs; a monitor compares them against the DUT after every edge.
module tb_parking_gate_ctrl;
    localparam int CAP = 2;
    localparam int TMO = 8;
    localparam int MT  = 3;
    localparam int LCK = 5;
    localparam int BD  = 2;
    localparam logic [3:0] PW = 4'hA;
    localparam int OW = $clog2(CAP + 1);

    localparam int M_IDLE = 0, M_WAIT = 1, M_WRONG = 2, M_GRANT = 3, M_STOP = 4, M_LOCK = 5;

    typedef struct packed {
        logic          gate;
        logic          green;
        logic          red;
        logic          alarm;
        logic          full;
        logic [OW-1:0] occ;
        logic [2:0]    st;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sensor_entrance = 1'b0, sensor_exit = 1'b0, lane_exit = 1'b0, pw_valid = 1'b0;
    logic [3:0] pw_data = 4'h0;
    logic gate_open, green_led, red_led, alarm, full;
    logic [OW-1:0] occupancy;
    logic [2:0] state_code;

    parking_gate_ctrl #(
        .CAPACITY(CAP), .PW_WIDTH(4), .PASSWORD(PW), .TIMEOUT_CYCLES(TMO),
        .MAX_TRIES(MT), .LOCK_CYCLES(LCK), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor_entrance(sensor_entrance),
        .sensor_exit(sensor_exit), .lane_exit(lane_exit), .pw_valid(pw_valid),
        .pw_data(pw_data), .gate_open(gate_open), .green_led(green_led),
        .red_led(red_led), .alarm(alarm), .full(full), .occupancy(occupancy),
        .state_code(state_code)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: lot state in plain integers.
    int ms = M_IDLE, tries = 0, waited = 0, lock_left = 0, occ = 0, edges = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.gate = gate_open; o.green = green_led; o.red = red_led; o.alarm = alarm;
        o.full = full; o.occ = occupancy; o.st = state_code;
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        logic blink;
        blink = ((edges / BD) % 2) == 1;
        o = '0;
        o.full = (occ == CAP);
        o.occ  = OW'(occ);
        o.st   = 3'(ms);
        case (ms)
            M_IDLE:  o.red = o.full;
            M_WAIT:  o.red = 1'b1;
            M_WRONG: o.red = blink;
            M_GRANT: begin o.green = blink; o.gate = 1'b1; end
            M_STOP:  begin o.red = blink; o.alarm = 1'b1; end
            M_LOCK:  begin o.red = 1'b1; o.alarm = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got gate=%0b grn=%0b red=%0b alm=%0b full=%0b occ=%0d st=%0d expected gate=%0b grn=%0b red=%0b alm=%0b full=%0b occ=%0d st=%0d",
                     name, $time, act.gate, act.green, act.red, act.alarm, act.full, act.occ, act.st,
                     exp.gate, exp.green, exp.red, exp.alarm, exp.full, exp.occ, exp.st);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit se, input bit sx, input bit le, input bit pv, input logic [3:0] pd);
        int nxt;
        bit inc;
        nxt = ms;
        inc = 0;
        case (ms)
            M_IDLE: begin
                tries = 0; waited = 0;
                if (se && occ < CAP) nxt = M_WAIT;
            end
            M_WAIT, M_WRONG: begin
                if (pv) begin
                    waited = 0;
                    if (pd == PW) nxt = M_GRANT;
                    else begin
                        tries++;
                        if (tries == MT) begin nxt = M_LOCK; lock_left = LCK; end
                        else nxt = M_WRONG;
                    end
                end else begin
                    waited++;
                    if (waited == TMO) begin nxt = M_IDLE; waited = 0; end
                end
            end
            M_GRANT: begin
                if (se && sx) nxt = M_STOP;
                else if (sx) begin nxt = M_IDLE; inc = 1; end
            end
            M_STOP: if (pv && pd == PW) nxt = M_GRANT;
            M_LOCK: begin
                lock_left--;
                if (lock_left == 0) begin nxt = M_IDLE; tries = 0; end
            end
            default: nxt = M_IDLE;
        endcase
        if (inc && !le) begin if (occ < CAP) occ++; end
        else if (le && !inc) begin if (occ > 0) occ--; end
        ms = nxt;
        edges++;
    endtask

    // Called at a falling edge: drive inputs, predict the next edge, wait a cycle.
    task automatic step(input bit se, input bit sx, input bit le, input bit pv, input logic [3:0] pd);
        sensor_entrance = se; sensor_exit = sx; lane_exit = le; pw_valid = pv; pw_data = pd;
        model_edge(se, sx, le, pv, pd);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        sensor_entrance = 0; sensor_exit = 0; lane_exit = 0; pw_valid = 0; pw_data = '0;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_obs(), '0);
        ms = M_IDLE; tries = 0; waited = 0; lock_left = 0; occ = 0; edges = 0;
        repeat (cycles) begin
            exp_q.push_back(model_out());
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", dut_obs(), e);
            end
        end
    end

    initial begin : driver
        @(negedge clk);
        do_reset(2);

        // Happy path
        step(1,0,0,0,0); step(0,0,0,1,PW); step(0,1,0,0,0);
        check_int("happy_occ", int'(occupancy), 1);

        // Lockout, then a try from IDLE without entrance is ignored
        step(1,0,0,0,0);
        repeat (3) step(0,0,0,1,4'h3);
        check_int("locked_state", int'(state_code), 5);
        repeat (LCK) step(0,0,0,0,0);
        check_int("lock_release", int'(state_code), 0);
        step(0,0,0,1,PW);
        check_int("idle_ignores_pw", int'(state_code), 0);

        // Timeout, and pw_valid on the terminal cycle winning
        step(1,0,0,0,0);
        repeat (TMO) step(0,0,0,0,0);
        check_int("timeout_idle", int'(state_code), 0);
        step(1,0,0,0,0);
        repeat (TMO - 1) step(0,0,0,0,0);
        step(0,0,0,1,PW);
        check_int("timeout_pw_priority", int'(state_code), 3);

        // Tailgate from GRANTED, wrong passwords ignored in STOP
        step(1,1,0,0,0);
        repeat (4) step(0,0,0,1,4'h3);
        check_int("stop_ignores_wrong", int'(state_code), 4);
        step(0,0,0,1,PW);
        step(0,1,0,0,0);
        check_int("full_flag", int'(full), 1);

        // Full lot: entrance refused, then drain past zero
        step(1,0,0,0,0);
        check_int("full_refuse", int'(state_code), 0);
        check_int("full_red", int'(red_led), 1);
        step(0,0,1,0,0);
        check_int("drain_occ", int'(occupancy), 1);
        step(0,0,1,0,0); step(0,0,1,0,0);
        check_int("drain_floor", int'(occupancy), 0);

        // Admit one, then admit with simultaneous lane exit
        step(1,0,0,0,0); step(0,0,0,1,PW); step(0,1,0,0,0);
        step(1,0,0,0,0); step(0,0,0,1,PW); step(0,1,1,0,0);
        check_int("simul_occ", int'(occupancy), 1);

        // Reset mid-WRONG
        step(1,0,0,0,0); step(0,0,0,1,4'h5);
        check_int("in_wrong", int'(state_code), 2);
        do_reset(2);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] pd;
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                pd = ($urandom_range(0, 1) == 1) ? PW : 4'($urandom_range(0, 15));
                step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 25, pd);
            end
        end

        repeat (3) @(negedge clk);
        check_int("queue_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
